pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Central pipeline controller for the six-stage core (PC, IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into the 6-bit stall vector consumed by every pipeline register, including the MEM/WB register.
- Sequences exception flushes and computes the redirect PC.
- Adds a stall watchdog that reports hung bus stalls, and a stall-cycle performance counter.

Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect target for all exceptions except eret
- TIMEOUT, 256, consecutive bus-stall cycles before bus_timeout pulses (legal range 2..65535)
- CNT_W, 32, width of the stall performance counter

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- stallreq_if  in  1  instruction bus wait
- stallreq_id  in  1  load-use hazard
- stallreq_ex  in  1  multi-cycle ALU op (div/madd) busy
- stallreq_mem  in  1  data bus wait
- excepttype_i  in  32  exception type from MEM stage; 0 = none
- cp0_epc_i  in  32  current EPC, forwarded value
- perf_clr  in  1  synchronous clear of the stall counter
- stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1 = hold stage
- flush  out  1  clear all pipeline registers this cycle
- new_pc  out  32  redirect target, valid when flush=1
- bus_timeout  out  1  one-cycle pulse to CP0 cause logic
- stall_cnt  out  CNT_W  cycles with stall!=0

Behaviour:
- Reset (rst=0, async): state=IDLE, wdog_cnt=0, stall_cnt=0, bus_timeout=0. While rst is low, stall=0, flush=0, new_pc=0.
- Stall vector: combinational, same-cycle, priority mem > ex > id > if.
  - stallreq_mem: 6'b011111. WB proceeds; MEM/WB loads a bubble.
  - stallreq_ex: 6'b001111.
  - stallreq_id: 6'b000111.
  - stallreq_if: 6'b000111.
  - None: 6'b000000.
- Flush decode: exc = (state==IDLE) && (excepttype_i != 0).
- When exc=1 (combinational, same cycle):
  - flush=1 and stall=6'b000000; flush overrides all stall requests.
  - new_pc = cp0_epc_i if excepttype_i==32'h0000_000e (eret), else EXC_VECTOR.
- When exc=0: new_pc=0.
- FSM has two states:
  - IDLE: on exc, go to RECOVER.
  - RECOVER: lasts exactly 1 cycle, then returns to IDLE.
    - excepttype_i is ignored; stale MEM contents are being flushed.
    - flush=0. The stall vector is computed normally from the requests.
- Back-to-back exceptions: an exception in the cycle right after a flush is not taken; it is re-evaluated once IDLE resumes.
- Watchdog:
  - bus_stall = stallreq_if | stallreq_mem, evaluated when flush=0.
  - wdog_cnt increments each bus_stall cycle and clears on any cycle without bus_stall or with flush=1.
  - When wdog_cnt==TIMEOUT-1 and bus_stall=1: bus_timeout=1 (registered, visible the next cycle) and wdog_cnt goes to 0.
  - If exc=1 in the same cycle, the timeout is suppressed and the counter cleared.
  - wdog_cnt width is 16 bits.
- Perf counter:
  - stall_cnt increments by 1 each cycle stall!=0; wraps modulo 2^CNT_W.
  - perf_clr=1 sets it to 0 next edge; clear wins over increment in the same cycle.
- Mid-operation reset: any state, counter or pending pulse is discarded immediately; outputs take reset values asynchronously.

Decomposition:
- Shared define package holds: stall bit masks (STALL_MEM=6'b011111, STALL_EX=6'b001111, STALL_ID=6'b000111), EXC_ERET=32'h0000_000e, Stop/NoStop, and the FSM state encodings IDLE/RECOVER.
- One natural sub-module: stall_watchdog (wdog_cnt plus bus_timeout pulse, parameter TIMEOUT).
- Stall priority encoding and the FSM stay in pipe_ctrl.

Test Plan:
- Reset: hold rst=0 with all requests high -> stall=0, flush=0, stall_cnt=0. Release -> stall=6'b011111 in the same cycle.
- Priority: stallreq_id=1 and stallreq_ex=1 -> stall=6'b001111. Add stallreq_mem=1 -> 6'b011111. Drop all -> 6'b000000 the same cycle.
- Exception plus stall: excepttype_i=32'h0000_0008, stallreq_mem=1 -> flush=1, stall=0, new_pc=32'h0000_0020. Next cycle excepttype_i still 8 -> flush=0 (RECOVER), stall=6'b011111. Cycle after -> flush=1 again.
- Eret: excepttype_i=32'h0000_000e, cp0_epc_i=32'h8000_1234 -> flush=1, new_pc=32'h8000_1234.
- Watchdog: TIMEOUT=4, stallreq_mem held 9 cycles -> bus_timeout pulses exactly once per 4 stalled cycles, at cycles 5 and 9 counted from the first stalled cycle. A single gap cycle at cycle 3 restarts the count.
- Perf counter: 10 stalled cycles -> stall_cnt=10. perf_clr asserted during a stalled cycle -> 0. Preload near 2^CNT_W-1 (CNT_W=8 build) and stall -> wraps to 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall masks, eret code, FSM states.
package pipe_ctrl_pkg;

  // A set bit holds the corresponding stage: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB.
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Counts consecutive bus-stall cycles and pulses bus_timeout once per TIMEOUT cycles.
module pipe_ctrl_stall_watchdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic bus_stall,   // already masked by flush
  output logic bus_timeout
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] wdog_cnt_q, wdog_cnt_d;
  logic        pulse_q, pulse_d;

  // Next count: restart on any idle cycle, wrap to zero when the timeout fires.
  always_comb begin
    wdog_cnt_d = '0;
    pulse_d    = 1'b0;
    if (bus_stall) begin
      if (wdog_cnt_q == LAST) begin
        pulse_d = 1'b1;
      end else begin
        wdog_cnt_d = wdog_cnt_q + 16'd1;
      end
    end
  end

  // Counter and registered pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_q <= '0;
      pulse_q    <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      pulse_q    <= pulse_d;
    end
  end

  assign bus_timeout = pulse_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall merge, exception flush/redirect, watchdog and stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int unsigned TIMEOUT    = 256,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  input  logic             perf_clr,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             bus_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e           state_q, state_d;
  logic             exc;
  logic [5:0]       stall_req;
  logic             bus_stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Exceptions arriving during RECOVER belong to stale MEM contents and are ignored.
  assign exc = (state_q == IDLE) && (excepttype_i != '0);

  // Stall priority: deepest requesting stage wins.
  always_comb begin
    stall_req = STALL_NONE;
    if (stallreq_mem) begin
      stall_req = STALL_MEM;
    end else if (stallreq_ex) begin
      stall_req = STALL_EX;
    end else if (stallreq_id || stallreq_if) begin
      stall_req = STALL_ID;
    end
  end

  // Outputs; forced quiet while reset is asserted, flush overrides stalls.
  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = '0;
    if (rst) begin
      if (exc) begin
        flush  = Stop;
        stall  = {6{NoStop}};
        new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
      end else begin
        stall = stall_req;
      end
    end
  end

  // Next state: RECOVER lasts exactly one cycle after each flush.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (exc) state_d = RECOVER;
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign bus_stall = (stallreq_if | stallreq_mem) & ~flush;

  pipe_ctrl_stall_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .bus_stall   (bus_stall),
    .bus_timeout (bus_timeout)
  );

  // Stall-cycle counter; clear has priority over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
    end else if (stall != STALL_NONE) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule
